// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serialises an NWORDS x DATA_BITS buffer onto an async serial line.
// Word 0 (most-significant slice) goes first, each word LSB first, with start bit,
// optional parity and 1 or 2 stop bits. No gap between words.
// Ports:
//   CLK    - system clock, rising edge
//   RESET  - asynchronous active-low reset
//   START  - level request; accepted when high in IDLE, dropping it aborts after the current word
//   BUFFER - frame payload, captured on the accept cycle
//   END    - high from frame completion until START is sampled low
//   BUSY   - high while a frame is being shifted out
//   SIGNAL - serial line, idle high
module serial_frame_tx #(
  parameter int unsigned NWORDS    = 5,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV       = 868,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic [NWORDS*DATA_BITS-1:0]   BUFFER,
  output logic                          END,
  output logic                          BUSY,
  output logic                          SIGNAL
);

  localparam int unsigned BUF_W  = NWORDS * DATA_BITS;
  localparam int unsigned WORD_W = $clog2(NWORDS + 1);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned CNT_W  = $clog2(DIV);

  // Elaboration-time rejection of unsupported configurations
  if (DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY > 2 ||
      DATA_BITS < 5 || DATA_BITS > 9 || NWORDS < 1) begin : g_param_check
    $error("serial_frame_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_STARTB, S_DATA, S_PAR, S_STOPB, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic                 stop_q, stop_d;
  logic [BUF_W-1:0]     shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 abort_q, abort_d;
  logic                 busy_q, busy_d;
  logic                 end_q, end_d;
  logic                 signal_q, signal_d;

  logic                 tick_c;
  logic [DATA_BITS-1:0] load_word_c;

  assign tick_c = (cnt_q == CNT_W'(DIV - 1));
  // Next word comes from BUFFER on accept, otherwise from the captured frame
  assign load_word_c = (state_q == S_IDLE) ? BUFFER[BUF_W-1 -: DATA_BITS]
                                           : shreg_q[BUF_W-1 -: DATA_BITS];

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      end_q    <= 1'b0;
      signal_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      stop_q   <= stop_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      par_q    <= par_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      end_q    <= end_d;
      signal_q <= signal_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    word_d   = word_q;
    stop_d   = stop_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    par_d    = par_q;
    abort_d  = abort_q;
    busy_d   = busy_q;
    end_d    = end_q;
    signal_d = signal_q;

    case (state_q)
      S_IDLE: begin
        signal_d = 1'b1;
        if (START) begin
          shreg_d  = BUFFER << DATA_BITS;
          data_d   = load_word_c;
          par_d    = ^load_word_c;
          word_d   = '0;
          bit_d    = '0;
          stop_d   = 1'b0;
          cnt_d    = '0;
          abort_d  = 1'b0;
          busy_d   = 1'b1;
          signal_d = 1'b0;
          state_d  = S_STARTB;
        end
      end

      S_DONE: begin
        if (!START) begin
          end_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        // A START drop anywhere in the frame is remembered until the word ends
        if (!START) abort_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_c) begin
          cnt_d = '0;
          case (state_q)
            S_STARTB: begin
              bit_d    = '0;
              signal_d = data_q[0];
              state_d  = S_DATA;
            end
            S_DATA: begin
              if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                if (PARITY != 0) begin
                  signal_d = par_q ^ (PARITY == 2);
                  state_d  = S_PAR;
                end else begin
                  stop_d   = 1'b0;
                  signal_d = 1'b1;
                  state_d  = S_STOPB;
                end
              end else begin
                bit_d    = bit_q + BIT_W'(1);
                data_d   = data_q >> 1;
                signal_d = data_q[1];
              end
            end
            S_PAR: begin
              stop_d   = 1'b0;
              signal_d = 1'b1;
              state_d  = S_STOPB;
            end
            S_STOPB: begin
              if (STOP_BITS == 2 && stop_q == 1'b0) begin
                stop_d = 1'b1;
              end else begin
                word_d = word_q + WORD_W'(1);
                if (abort_q || !START) begin
                  busy_d   = 1'b0;
                  signal_d = 1'b1;
                  state_d  = S_IDLE;
                end else if (word_q == WORD_W'(NWORDS - 1)) begin
                  busy_d   = 1'b0;
                  end_d    = 1'b1;
                  signal_d = 1'b1;
                  state_d  = S_DONE;
                end else begin
                  data_d   = load_word_c;
                  par_d    = ^load_word_c;
                  shreg_d  = shreg_q << DATA_BITS;
                  bit_d    = '0;
                  signal_d = 1'b0;
                  state_d  = S_STARTB;
                end
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  assign END    = end_q;
  assign BUSY   = busy_q;
  assign SIGNAL = signal_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (8N1, 8E2, 8O2) at DIV=4, directed frames
// compared cycle by cycle against a bit-sequence model built from the payload.
module tb_serial_frame_tx;

  localparam int unsigned DIV = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_v [3];
  logic [39:0] buf_v   [3];
  logic        end_v   [3];
  logic        busy_v  [3];
  logic        sig_v   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.NWORDS(5), .DATA_BITS(8), .DIV(DIV), .PARITY(0), .STOP_BITS(1)) dut_a (
    .CLK(clk), .RESET(rst_n), .START(start_v[0]), .BUFFER(buf_v[0]),
    .END(end_v[0]), .BUSY(busy_v[0]), .SIGNAL(sig_v[0]));

  serial_frame_tx #(.NWORDS(5), .DATA_BITS(8), .DIV(DIV), .PARITY(1), .STOP_BITS(2)) dut_b (
    .CLK(clk), .RESET(rst_n), .START(start_v[1]), .BUFFER(buf_v[1]),
    .END(end_v[1]), .BUSY(busy_v[1]), .SIGNAL(sig_v[1]));

  serial_frame_tx #(.NWORDS(5), .DATA_BITS(8), .DIV(DIV), .PARITY(2), .STOP_BITS(2)) dut_c (
    .CLK(clk), .RESET(rst_n), .START(start_v[2]), .BUFFER(buf_v[2]),
    .END(end_v[2]), .BUSY(busy_v[2]), .SIGNAL(sig_v[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Runs one frame on instance sel; cycle 0 is the accept edge.
  // exp_end is the hand-computed cycle where BUSY falls; abort_at<0 means no abort.
  task automatic run_frame(input int sel, input logic [39:0] data, input int par,
                           input int stops, input int exp_end, input int abort_at,
                           input logic exp_par);
    logic       seq[$];
    logic [7:0] w8;
    for (int w = 0; w < 5; w++) begin
      w8 = data[39-8*w -: 8];
      seq.push_back(1'b0);
      for (int b = 0; b < 8; b++) seq.push_back(w8[b]);
      if (par != 0) seq.push_back((^w8) ^ (par == 2));
      for (int s = 0; s < stops; s++) seq.push_back(1'b1);
    end
    buf_v[sel]   = data;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= exp_end + 3; c++) begin
      if (c < exp_end) begin
        check("sig", 64'(sig_v[sel]), 64'(seq[c / DIV]));
        check("busy", 64'(busy_v[sel]), 64'd1);
        check("end_low", 64'(end_v[sel]), 64'd0);
      end else begin
        check("sig_idle", 64'(sig_v[sel]), 64'd1);
        check("busy_fall", 64'(busy_v[sel]), 64'd0);
        check("end_rise", 64'(end_v[sel]), (abort_at < 0) ? 64'd1 : 64'd0);
      end
      if (par != 0 && c == 36) check("par_bit", 64'(sig_v[sel]), 64'(exp_par));
      if (sel == 0 && c == 4)  check("w0_b0", 64'(sig_v[sel]), 64'd1);
      if (sel == 0 && c == 8)  check("w0_b1", 64'(sig_v[sel]), 64'd0);
      if (c == 10) buf_v[sel] = '1;
      if (abort_at >= 0) begin
        if (c == abort_at)      start_v[sel] = 1'b0;
        if (c == abort_at + 10) start_v[sel] = 1'b1;
        if (c == abort_at + 20) start_v[sel] = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  // Drops START for one cycle and confirms the END handshake closes
  task automatic close_frame(input int sel);
    start_v[sel] = 1'b0;
    @(posedge clk); #1;
    check("end_clr", 64'(end_v[sel]), 64'd0);
    check("busy_clr", 64'(busy_v[sel]), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      buf_v[i]   = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_sig", 64'(sig_v[0]), 64'd1);
    check("rst_busy", 64'(busy_v[0]), 64'd0);
    check("rst_end", 64'(end_v[0]), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 8N1 frame with buffer overwritten mid-frame
    run_frame(0, 40'h0102030405, 0, 1, 200, -1, 1'b0);
    repeat (50) begin
      check("end_hold", 64'(end_v[0]), 64'd1);
      @(posedge clk); #1;
    end
    close_frame(0);
    run_frame(0, 40'h0102030405, 0, 1, 200, -1, 1'b0);
    close_frame(0);

    // Even and odd parity with two stop bits
    run_frame(1, 40'h0301020405, 1, 2, 240, -1, 1'b0);
    close_frame(1);
    run_frame(2, 40'h0301020405, 2, 2, 240, -1, 1'b1);
    close_frame(2);

    // Abort during word 2 data bits; word 2 ends at cycle 120
    run_frame(0, 40'h0102030405, 0, 1, 120, 90, 1'b0);
    repeat (40) begin
      check("abort_sig", 64'(sig_v[0]), 64'd1);
      check("abort_busy", 64'(busy_v[0]), 64'd0);
      check("abort_end", 64'(end_v[0]), 64'd0);
      @(posedge clk); #1;
    end

    // Asynchronous reset while the start bit is on the line
    buf_v[0]   = 40'h0102030405;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_sig", 64'(sig_v[0]), 64'd0);
    check("pre_rst_busy", 64'(busy_v[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sig", 64'(sig_v[0]), 64'd1);
    check("mid_rst_busy", 64'(busy_v[0]), 64'd0);
    check("mid_rst_end", 64'(end_v[0]), 64'd0);
    start_v[0] = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
